demux_lane_collector: RTL and testbench

- Downstream consumer of the 1-to-4 single-bit demultiplexer, which routes serial bit f onto one of lanes a/b/c/d by selector.
- Reassembles each lane's bit stream into WORD_W-bit words in four per-lane shift registers.
- Arbitrates completed words round-robin into one registered valid/ready output slot.
- Flags demux invariant violations (non-selected lane high) and per-lane overflow.

---
 rtl/demux_lane_collector_pkg.sv | 22 ++
 rtl/demux_lane_collector_rr_arb4.sv | 32 +++
 rtl/demux_lane_collector.sv | 105 ++++++++++
 tb/tb_demux_lane_collector.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_lane_collector_pkg.sv
// Shared lane constants and helpers for the demux lane collector.
// Words are assembled MSB-first: the first bit received on a lane ends up in bit WORD_W-1.
package demux_lane_collector_pkg;

    localparam int NUM_LANES  = 4;
    localparam int LANE_IDX_W = 2;

    typedef logic [LANE_IDX_W-1:0] lane_idx_t;

    localparam lane_idx_t LANE_A = 2'd0;
    localparam lane_idx_t LANE_B = 2'd1;
    localparam lane_idx_t LANE_C = 2'd2;
    localparam lane_idx_t LANE_D = 2'd3;

    function automatic logic [NUM_LANES-1:0] lane_onehot(input lane_idx_t idx);
        logic [NUM_LANES-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/demux_lane_collector_rr_arb4.sv
// Combinational 4-way round-robin arbiter: first request at or after ptr, ascending mod 4.
// The pointer register lives in the parent.
module rr_arb4
    import demux_lane_collector_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic       grant_valid,
    output logic [1:0] grant_idx
);

    logic [7:0] req2;
    logic [3:0] rot;
    logic [1:0] offs;

    // Doubling the vector turns the modulo rotation into a plain part-select.
    assign req2 = {req, req};
    assign rot  = req2[ptr +: 4];

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        offs = 2'd0;
        if (rot[0])      offs = 2'd0;
        else if (rot[1]) offs = 2'd1;
        else if (rot[2]) offs = 2'd2;
        else if (rot[3]) offs = 2'd3;
    end

    assign grant_valid = |rot;
    assign grant_idx   = lane_idx_t'(ptr + offs);

endmodule

// File: rtl/demux_lane_collector.sv
// Reassembles the four demux lanes into WORD_W-bit words and hands them out one at a time
// through a registered valid/ready slot, flagging demux protocol errors and lane overflow.
module demux_lane_collector
    import demux_lane_collector_pkg::*;
#(
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [1:0]        lane_sel,
    input  logic [3:0]        lane_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic [1:0]        out_lane,
    output logic [3:0]        ovf,
    output logic              proto_err,
    input  logic              clr_flags
);

    localparam int              CNT_W    = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_W);

    logic [WORD_W-1:0]    shreg [NUM_LANES];
    logic [CNT_W-1:0]     cnt   [NUM_LANES];
    logic [NUM_LANES-1:0] full;
    logic [NUM_LANES-1:0] sel_oh;
    logic [NUM_LANES-1:0] ovf_set;
    logic                 proto_set;
    logic                 cap_bit;
    logic                 slot_free;
    logic                 load;
    logic                 grant_valid;
    lane_idx_t            grant_idx;
    lane_idx_t            rr_ptr;

    always_comb begin
        full = '0;
        for (int k = 0; k < NUM_LANES; k++) full[k] = (cnt[k] == CNT_FULL);
    end

    assign sel_oh    = lane_onehot(lane_sel);
    assign cap_bit   = lane_in[lane_sel];
    assign ovf_set   = in_valid ? (sel_oh & full) : '0;
    assign proto_set = in_valid && |(lane_in & ~sel_oh);
    assign slot_free = !out_valid || out_ready;
    assign load      = slot_free && grant_valid;

    rr_arb4 u_arb (
        .req         (full),
        .ptr         (rr_ptr),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // A granted lane is always full, so it can never also capture in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the lane arrays are reset explicitly; a partial word must never survive a reset.
            for (int k = 0; k < NUM_LANES; k++) begin
                shreg[k] <= '0;
                cnt[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_LANES; k++) begin
                if (load && grant_idx == lane_idx_t'(k)) begin
                    cnt[k] <= '0;
                end else if (in_valid && sel_oh[k] && !full[k]) begin
                    // NOTE: state updates use non-blocking assignment so every lane sees pre-edge values.
                    shreg[k] <= {shreg[k][WORD_W-2:0], cap_bit};
                    cnt[k]   <= cnt[k] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_lane  <= LANE_A;
            rr_ptr    <= LANE_A;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= shreg[grant_idx];
            out_lane  <= grant_idx;
            rr_ptr    <= lane_idx_t'(grant_idx + 2'd1);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Flags are sticky; a set event in the clearing cycle still wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf       <= '0;
            proto_err <= 1'b0;
        end else begin
            ovf       <= (clr_flags ? 4'b0000 : ovf) | ovf_set;
            proto_err <= (proto_err && !clr_flags) || proto_set;
        end
    end

endmodule

// File: tb/tb_demux_lane_collector.sv
// Scenario bench for demux_lane_collector: expected words are queued as stimulus is driven
// and popped by a monitor whenever the output slot transfers.
module tb_demux_lane_collector;

    typedef struct packed {
        logic [1:0] lane;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [1:0] lane_sel = 2'd0;
    logic [3:0] lane_in = 4'd0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic [1:0] out_lane;
    logic [3:0] ovf;
    logic       proto_err;
    logic       clr_flags = 1'b0;

    int   total = 0;
    int   bad = 0;
    exp_t sb[$];

    demux_lane_collector #(.WORD_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .lane_sel  (lane_sel),
        .lane_in   (lane_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_lane  (out_lane),
        .ovf       (ovf),
        .proto_err (proto_err),
        .clr_flags (clr_flags)
    );

    always #5 clk = ~clk;

    // Inputs change 1ns after the rising edge, so at the falling edge out_valid && out_ready
    // means the word transfers on the next rising edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_word: got lane=%0d data=%02h, queue empty", out_lane, out_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (out_lane !== e.lane || out_data !== e.data) begin
                    bad++;
                    $display("FAIL word: got lane=%0d data=%02h required lane=%0d data=%02h",
                             out_lane, out_data, e.lane, e.data);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic push(input logic [1:0] lane, input logic [7:0] data);
        exp_t e;
        e.lane = lane;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic send_bit(input int lane, input logic b, input logic [3:0] extra);
        logic [3:0] v;
        v       = extra;
        v[lane] = b;
        in_valid = 1'b1;
        lane_sel = lane[1:0];
        lane_in  = v;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lane_in  = 4'd0;
    endtask

    task automatic send_word(input int lane, input logic [7:0] w);
        for (int i = 7; i >= 0; i--) send_bit(lane, w[i], 4'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while (sb.size() != 0 && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: pending=%0d required=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        total++;
        if ({out_valid, out_data, out_lane, ovf, proto_err} !== 16'd0) begin
            bad++;
            $display("FAIL reset_state: got v=%b d=%02h l=%0d ovf=%b pe=%b required all 0",
                     out_valid, out_data, out_lane, ovf, proto_err);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single_word();
        out_ready = 1'b1;
        push(2'd0, 8'hB2);
        send_word(0, 8'hB2);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL latency_early: got out_valid=%b required 0", out_valid);
        end
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'hB2 || out_lane !== 2'd0) begin
            bad++;
            $display("FAIL single_word: got v=%b d=%02h l=%0d required v=1 d=b2 l=0",
                     out_valid, out_data, out_lane);
        end
        total++;
        if (ovf !== 4'd0 || proto_err !== 1'b0) begin
            bad++;
            $display("FAIL single_flags: got ovf=%b pe=%b required 0000 0", ovf, proto_err);
        end
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_drop: got out_valid=%b required 0", out_valid);
        end
        drain(5);
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        push(2'd1, 8'hFF);
        push(2'd2, 8'h00);
        for (int r = 0; r < 8; r++) begin
            send_bit(1, 1'b1, 4'd0);
            send_bit(2, 1'b0, 4'd0);
        end
        for (int c = 0; c < 3; c++) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== 8'hFF || out_lane !== 2'd1) begin
                bad++;
                $display("FAIL hold_stable: cycle=%0d got v=%b d=%02h l=%0d required v=1 d=ff l=1",
                         c, out_valid, out_data, out_lane);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'h00 || out_lane !== 2'd2) begin
            bad++;
            $display("FAIL no_bubble: got v=%b d=%02h l=%0d required v=1 d=00 l=2",
                     out_valid, out_data, out_lane);
        end
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_drop: got out_valid=%b required 0", out_valid);
        end
        drain(5);
    endtask

    task automatic test_round_robin();
        logic [7:0] w [4];
        w[0] = 8'h81; w[1] = 8'h42; w[2] = 8'h24; w[3] = 8'h18;
        do_reset();
        out_ready = 1'b0;
        // Granting lane 1 leaves the pointer at 2 with the slot occupied.
        push(2'd1, 8'hA5);
        send_word(1, 8'hA5);
        for (int i = 7; i >= 0; i--)
            for (int k = 0; k < 4; k++) send_bit(k, w[k][i], 4'd0);
        push(2'd2, w[2]);
        push(2'd3, w[3]);
        push(2'd0, w[0]);
        push(2'd1, w[1]);
        total++;
        if (out_valid !== 1'b1 || out_lane !== 2'd1 || out_data !== 8'hA5) begin
            bad++;
            $display("FAIL rr_hold: got v=%b d=%02h l=%0d required v=1 d=a5 l=1",
                     out_valid, out_data, out_lane);
        end
        out_ready = 1'b1;
        drain(40);
        total++;
        if (ovf !== 4'd0) begin
            bad++;
            $display("FAIL rr_ovf: got ovf=%b required 0000", ovf);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        out_ready = 1'b0;
        push(2'd0, 8'h3C);
        send_word(0, 8'h3C);
        push(2'd3, 8'hC3);
        send_word(3, 8'hC3);
        send_bit(3, 1'b1, 4'd0);
        total++;
        if (ovf !== 4'b1000) begin
            bad++;
            $display("FAIL ovf_set: got ovf=%b required 1000", ovf);
        end
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'h3C || out_lane !== 2'd0) begin
            bad++;
            $display("FAIL ovf_slot: got v=%b d=%02h l=%0d required v=1 d=3c l=0",
                     out_valid, out_data, out_lane);
        end
        clr_flags = 1'b1;
        @(posedge clk); #1;
        clr_flags = 1'b0;
        total++;
        if (ovf !== 4'd0) begin
            bad++;
            $display("FAIL ovf_clear: got ovf=%b required 0000", ovf);
        end
        out_ready = 1'b1;
        drain(10);
    endtask

    task automatic test_proto_err();
        do_reset();
        out_ready = 1'b1;
        send_bit(1, 1'b1, 4'b0100);
        total++;
        if (proto_err !== 1'b1) begin
            bad++;
            $display("FAIL proto_set: got proto_err=%b required 1", proto_err);
        end
        push(2'd1, 8'h80);
        for (int i = 0; i < 7; i++) send_bit(1, 1'b0, 4'd0);
        drain(5);
        clr_flags = 1'b1;
        send_bit(2, 1'b0, 4'b0001);
        clr_flags = 1'b0;
        total++;
        if (proto_err !== 1'b1) begin
            bad++;
            $display("FAIL proto_set_wins: got proto_err=%b required 1", proto_err);
        end
        clr_flags = 1'b1;
        @(posedge clk); #1;
        clr_flags = 1'b0;
        total++;
        if (proto_err !== 1'b0) begin
            bad++;
            $display("FAIL proto_clear: got proto_err=%b required 0", proto_err);
        end
    endtask

    task automatic test_reset_mid_word();
        int seen = 0;
        do_reset();
        out_ready = 1'b0;
        send_word(2, 8'hE7);
        send_bit(0, 1'b1, 4'b0010);
        for (int i = 0; i < 4; i++) send_bit(0, 1'b1, 4'd0);
        #3 rst_n = 1'b0;
        #1;
        total++;
        if ({out_valid, out_data, out_lane, ovf, proto_err} !== 16'd0) begin
            bad++;
            $display("FAIL async_reset: got v=%b d=%02h l=%0d ovf=%b pe=%b required all 0",
                     out_valid, out_data, out_lane, ovf, proto_err);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        push(2'd0, 8'h5A);
        send_word(0, 8'h5A);
        drain(5);
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL extra_word: got %0d valid cycles after drain required 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_round_robin();
        test_overflow();
        test_proto_err();
        test_reset_mid_word();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
